// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - AXI4 4-beat INCR burst master, one outstanding transaction
// Optional handshake watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_burst_master #(
  parameter int WIDTH_ID    = 2,
  parameter int WIDTH_DA    = 32,
  parameter int WIDTH_AD    = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [WIDTH_AD-1:0]   req_addr,
  input  logic [4*WIDTH_DA-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [4*WIDTH_DA-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [WIDTH_ID-1:0]   M_AXI_AWID,
  output logic [WIDTH_AD-1:0]   M_AXI_AWADDR,
  output logic [3:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [WIDTH_DA-1:0]   M_AXI_WDATA,
  output logic [WIDTH_DA/8-1:0] M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [WIDTH_ID-1:0]   M_AXI_BID,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [WIDTH_ID-1:0]   M_AXI_ARID,
  output logic [WIDTH_AD-1:0]   M_AXI_ARADDR,
  output logic [3:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [WIDTH_ID-1:0]   M_AXI_RID,
  input  logic [WIDTH_DA-1:0]   M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam logic [2:0] P_SIZE = 3'($clog2(WIDTH_DA/8));

  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_XFER, S_WR_RESP, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [WIDTH_AD-1:0]   r_addr;
  logic [4*WIDTH_DA-1:0] r_wdata;
  logic [3*WIDTH_DA-1:0] r_line;
  logic [4*WIDTH_DA-1:0] r_rdata;
  logic [1:0]            r_cnt;
  logic                  r_aw_done, r_w_done, r_err;
  logic                  w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready, w_tmo_hit;
  logic                  w_accept, w_beat3, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_beat3  = (r_cnt == 2'd3);
  assign w_ar_hs  = w_arvalid && M_AXI_ARREADY;
  assign w_r_hs   = w_rready && M_AXI_RVALID;
  assign w_aw_hs  = w_awvalid && M_AXI_AWREADY;
  assign w_w_hs   = w_wvalid && M_AXI_WREADY;
  assign w_b_hs   = w_bready && M_AXI_BVALID;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Valids come only from registered state/flags, so none depends on a ready.
  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    case (r_state)
      S_IDLE:    if (req_valid) w_state_nxt = req_we ? S_WR_XFER : S_RD_ADDR;
      S_RD_ADDR: begin
        w_arvalid = 1'b1;
        if (M_AXI_ARREADY) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_rready = 1'b1;
        if (M_AXI_RVALID && w_beat3) w_state_nxt = S_DONE;
      end
      S_WR_XFER: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if ((r_aw_done || M_AXI_AWREADY) && (r_w_done || (M_AXI_WREADY && w_beat3)))
          w_state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        w_bready = 1'b1;
        if (M_AXI_BVALID) w_state_nxt = S_DONE;
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_tmo_hit) begin
      w_arvalid   = 1'b0;
      w_rready    = 1'b0;
      w_awvalid   = 1'b0;
      w_wvalid    = 1'b0;
      w_bready    = 1'b0;
      w_state_nxt = S_DONE;
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_line    <= '0;
      r_rdata   <= '0;
      r_cnt     <= 2'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= req_addr;
        r_wdata   <= req_wdata;
        r_cnt     <= 2'd0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_err     <= 1'b0;
      end
      if (w_r_hs) begin
        r_cnt <= r_cnt + 2'd1;
        if (!w_beat3) r_line[r_cnt*WIDTH_DA +: WIDTH_DA] <= M_AXI_RDATA;
        else          r_rdata <= {M_AXI_RDATA, r_line};
        if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != w_beat3) r_err <= 1'b1;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) begin
        r_cnt <= r_cnt + 2'd1;
        if (w_beat3) r_w_done <= 1'b1;
      end
      if (w_b_hs && M_AXI_BRESP != 2'b00) r_err <= 1'b1;
      if (w_tmo_hit) r_err <= 1'b1;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int W_TMO = $clog2(TIMEOUT_CYC + 1);
  logic [W_TMO-1:0] r_tmo;
  logic             w_any_hs;
  logic             w_unused;

  assign w_any_hs  = w_ar_hs || w_r_hs || w_aw_hs || w_w_hs || w_b_hs;
  assign w_tmo_hit = (r_tmo == W_TMO'(TIMEOUT_CYC)) && (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_unused  = &{1'b0, M_AXI_BID, M_AXI_RID};

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) r_tmo <= '0;
    else if (r_state == S_IDLE || r_state == S_DONE || w_state_nxt != r_state || w_any_hs)
      r_tmo <= '0;
    else r_tmo <= r_tmo + 1'b1;
  end
`else
  logic w_unused;
  assign w_tmo_hit = 1'b0;
  assign w_unused  = &{1'b0, M_AXI_BID, M_AXI_RID, (TIMEOUT_CYC == 0)};
`endif

  assign req_ready     = (r_state == S_IDLE);
  assign rsp_valid     = (r_state == S_DONE);
  assign rsp_err       = rsp_valid && r_err;
  assign rsp_rdata     = r_rdata;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = 4'd3;
  assign M_AXI_AWSIZE  = P_SIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = w_awvalid;
  assign M_AXI_WDATA   = r_wdata[r_cnt*WIDTH_DA +: WIDTH_DA];
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = w_wvalid && w_beat3;
  assign M_AXI_WVALID  = w_wvalid;
  assign M_AXI_BREADY  = w_bready;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = 4'd3;
  assign M_AXI_ARSIZE  = P_SIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = w_arvalid;
  assign M_AXI_RREADY  = w_rready;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - directed self-checking bench for axi_burst_master
module tb_axi_burst_master;

  logic         M_AXI_ACLK = 1'b0;
  logic         M_AXI_ARESET;
  logic         req_valid, req_ready, req_we;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         rsp_valid, rsp_err;
  logic [127:0] rsp_rdata;
  logic [1:0]   M_AXI_AWID, M_AXI_ARID, M_AXI_BID, M_AXI_RID;
  logic [31:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]   M_AXI_AWLEN, M_AXI_ARLEN, M_AXI_WSTRB;
  logic [2:0]   M_AXI_AWSIZE, M_AXI_ARSIZE;
  logic [1:0]   M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
  logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic         M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  int n_total = 0;
  int n_bad   = 0;

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  axi_burst_master #(.WIDTH_ID(2), .WIDTH_DA(32), .WIDTH_AD(32), .TIMEOUT_CYC(16)) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Zero-wait read slave; keeps offering beats after the 4th to catch over-consumption.
  task automatic do_read(input logic [31:0] addr, input logic [127:0] line,
                         input logic [3:0] resp_mask, input logic [3:0] last_mask,
                         input bit hold_req, output int rsp_cyc,
                         output logic [127:0] rd, output logic er, output int nbeats);
    bit ar_done = 0;
    int nbusy = 0;
    int b;
    rsp_cyc = -1; nbeats = 0; rd = '0; er = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    for (int cyc = 1; cyc < 40 && rsp_cyc < 0; cyc++) begin
      @(posedge M_AXI_ACLK); #1;
      if (!hold_req) req_valid = 1'b0;
      M_AXI_ARREADY = 1'b1;
      b = (nbeats < 4) ? nbeats : 3;
      M_AXI_RVALID = ar_done;
      M_AXI_RDATA  = (nbeats < 4) ? line[b*32 +: 32] : 32'hDEADBEEF;
      M_AXI_RLAST  = last_mask[b];
      M_AXI_RRESP  = resp_mask[b] ? 2'b10 : 2'b00;
      if (M_AXI_ARVALID) begin
        chk("araddr", M_AXI_ARADDR, addr);
        chk("ar_fields", {M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST}, {4'd3, 3'd2, 2'b01});
        ar_done = 1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) nbeats++;
      if (req_ready) nbusy++;
      if (rsp_valid) begin
        rsp_cyc = cyc; rd = rsp_rdata; er = rsp_err;
      end
    end
    M_AXI_RVALID = 1'b0; M_AXI_ARREADY = 1'b0; req_valid = 1'b0;
    chk("rd_busy_ready", nbusy, 0);
    @(posedge M_AXI_ACLK); #1;
    chk("rd_ready_back", req_ready, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] line,
                          input int aw_wait, input bit toggle_w, input logic [1:0] bresp,
                          output int b_cyc, output int rsp_cyc, output logic er, output int npulse);
    bit aw_done = 0;
    bit b_done = 0;
    int nw = 0;
    b_cyc = -1; rsp_cyc = -1; er = 1'b0; npulse = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = line;
    for (int cyc = 1; cyc < 40; cyc++) begin
      @(posedge M_AXI_ACLK); #1;
      req_valid = 1'b0;
      M_AXI_AWREADY = (cyc > aw_wait);
      M_AXI_WREADY  = toggle_w ? cyc[0] : 1'b1;
      M_AXI_BVALID  = aw_done && (nw == 4) && !b_done;
      M_AXI_BRESP   = bresp;
      if (M_AXI_AWVALID) begin
        chk("awaddr", M_AXI_AWADDR, addr);
        chk("aw_fields", {M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST}, {4'd3, 3'd2, 2'b01});
        if (M_AXI_AWREADY) aw_done = 1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        chk("wdata", M_AXI_WDATA, line[nw*32 +: 32]);
        chk("wlast", M_AXI_WLAST, (nw == 3));
        chk("wstrb", M_AXI_WSTRB, 4'hF);
        nw++;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        b_cyc = cyc; b_done = 1;
      end
      if (rsp_valid) begin
        npulse++;
        if (rsp_cyc < 0) begin
          rsp_cyc = cyc; er = rsp_err;
        end
      end
      if (rsp_cyc >= 0 && cyc >= rsp_cyc + 2) break;
    end
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    chk("wr_beats", nw, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] l_rd;
    logic [127:0] l_last;
    logic         l_er;
    int           l_rc, l_bc, l_nb, l_np;

    M_AXI_ARESET = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
    M_AXI_BID = '0; M_AXI_BRESP = '0; M_AXI_BVALID = 1'b0;
    M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
    repeat (3) @(posedge M_AXI_ACLK);
    #1;
    chk("rst_handshakes", {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST,
                           M_AXI_RREADY, M_AXI_BREADY, rsp_valid, rsp_err}, 8'h00);
    chk("rst_rdata", rsp_rdata, 128'h0);
    chk("rst_addr_wdata", {M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA}, 96'h0);
    M_AXI_ARESET = 1'b0;
    @(posedge M_AXI_ACLK); #1;
    chk("rst_req_ready", req_ready, 1'b1);

    l_last = 128'h00000044_00000033_00000022_00000011;
    do_read(32'h10, l_last, 4'b0000, 4'b1000, 0, l_rc, l_rd, l_er, l_nb);
    chk("rd0_rsp_cyc", l_rc, 6);
    chk("rd0_rdata", l_rd, l_last);
    chk("rd0_err", l_er, 1'b0);
    chk("rd0_beats", l_nb, 4);

    do_write(32'h20, 128'h0000000D_0000000C_0000000B_0000000A, 3, 1, 2'b00, l_bc, l_rc, l_er, l_np);
    chk("wr_slow_b_cyc", l_bc, 8);
    chk("wr_slow_rsp_cyc", l_rc, l_bc + 1);
    chk("wr_slow_pulses", l_np, 1);
    chk("wr_slow_err", l_er, 1'b0);
    chk("wr_keeps_rdata", rsp_rdata, l_last);

    do_write(32'h30, 128'h44444444_33333333_22222222_11111111, 0, 0, 2'b00, l_bc, l_rc, l_er, l_np);
    chk("wr_fast_b_cyc", l_bc, 5);
    chk("wr_fast_rsp_cyc", l_rc, 6);
    chk("wr_fast_err", l_er, 1'b0);

    do_write(32'h34, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 3, 0, 2'b11, l_bc, l_rc, l_er, l_np);
    chk("wr_same_b_cyc", l_bc, 5);
    chk("wr_bresp_err", l_er, 1'b1);
    chk("wr_bresp_pulses", l_np, 1);

    l_last = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
    do_read(32'h100, l_last, 4'b0010, 4'b1000, 0, l_rc, l_rd, l_er, l_nb);
    chk("rd_rresp_err", l_er, 1'b1);
    chk("rd_rresp_beats", l_nb, 4);
    chk("rd_rresp_rdata", l_rd, l_last);

    l_last = 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1;
    do_read(32'h200, l_last, 4'b0000, 4'b1100, 0, l_rc, l_rd, l_er, l_nb);
    chk("rd_early_last_err", l_er, 1'b1);
    chk("rd_early_last_beats", l_nb, 4);

    l_last = 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1;
    do_read(32'h300, l_last, 4'b0000, 4'b1000, 1, l_rc, l_rd, l_er, l_nb);
    chk("rd_hold_rsp_cyc", l_rc, 6);
    chk("rd_hold_rdata", l_rd, l_last);

    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      @(posedge M_AXI_ACLK); #1;
      req_valid = 1'b0;
      M_AXI_ARREADY = 1'b1;
      if (c >= 2) begin
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h100 + c; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
      end
    end
    M_AXI_ARESET = 1'b1;
    #1;
    chk("rst_mid_valids", {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID,
                           M_AXI_WLAST, M_AXI_BREADY, rsp_valid}, 7'h00);
    chk("rst_mid_rdata", rsp_rdata, 128'h0);
    @(posedge M_AXI_ACLK); #1;
    M_AXI_ARESET = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_ARREADY = 1'b0;
    l_np = 0;
    repeat (8) begin
      @(posedge M_AXI_ACLK); #1;
      if (rsp_valid) l_np++;
    end
    chk("rst_no_rsp", l_np, 0);
    chk("rst_ready_again", req_ready, 1'b1);

    l_last = 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1;
    do_read(32'h400, l_last, 4'b0000, 4'b1000, 0, l_rc, l_rd, l_er, l_nb);
    chk("rd_post_rst_cyc", l_rc, 6);
    chk("rd_post_rst_rdata", l_rd, l_last);
    chk("rd_post_rst_err", l_er, 1'b0);

`ifdef AXI_MASTER_TIMEOUT_EN
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h50; M_AXI_ARREADY = 1'b0;
    l_nb = 0; l_rc = -1; l_er = 1'b0;
    for (int c = 1; c < 40 && l_rc < 0; c++) begin
      @(posedge M_AXI_ACLK); #1;
      req_valid = 1'b0;
      if (M_AXI_ARVALID) l_nb++;
      if (rsp_valid) begin
        l_rc = c; l_er = rsp_err;
      end
    end
    chk("tmo_arvalid_cycles", l_nb, 16);
    chk("tmo_rsp_cyc", l_rc, 18);
    chk("tmo_err", l_er, 1'b1);
    chk("tmo_keeps_rdata", rsp_rdata, l_last);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
